// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, sync bundle type,
// colour byte lanes of the palette word and frame-total helpers.
package vga_pkg;

    // 640x480@60 timing, 25.175 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Byte lanes of the 24-bit palette word
    localparam int B_LSB = 16;
    localparam int G_LSB = 8;
    localparam int R_LSB = 0;

    // Raster-stage control bits travelling down the alignment delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    function automatic int calc_h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int calc_v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with sync/blank decode and frame-level strobes.
// hs/vs leave here already at their configured active level.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic iVGA_CLK,
    input  logic iRST_n,
    output logic hs,
    output logic vs,
    output logic active,
    output logic line_last,     // last visible pixel of a visible line
    output logic frame_last,    // last clock of the frame
    output logic vblank_start,  // first blanking clock after the last visible pixel
    output logic frame_start    // counters sit on pixel (0,0)
);
    localparam int H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HCNT_W  = $clog2(H_TOTAL + 1);
    localparam int VCNT_W  = $clog2(V_TOTAL + 1);

    localparam logic [HCNT_W-1:0] H_ACT_C    = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_LAST_ACT = HCNT_W'(H_ACTIVE - 1);
    localparam logic [HCNT_W-1:0] HS_START   = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HS_END     = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT_C    = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_LAST_ACT = VCNT_W'(V_ACTIVE - 1);
    localparam logic [VCNT_W-1:0] VS_START   = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VS_END     = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VCNT_W-1:0] V_LAST     = VCNT_W'(V_TOTAL - 1);

    logic [HCNT_W-1:0] hcnt_reg, hcnt_next;
    logic [VCNT_W-1:0] vcnt_reg, vcnt_next;
    logic              frame_start_reg;
    logic              h_vis, v_vis;

    // Next raster position: hcnt wraps every line, vcnt steps on that wrap
    always_comb begin
        hcnt_next = hcnt_reg + 1'b1;
        vcnt_next = vcnt_reg;
        if (hcnt_reg == H_LAST) begin
            hcnt_next = '0;
            vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
        end
    end

    // Counter state; frame_start is registered so it stays low straight out of reset
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hcnt_reg        <= '0;
            vcnt_reg        <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            hcnt_reg        <= hcnt_next;
            vcnt_reg        <= vcnt_next;
            frame_start_reg <= (hcnt_next == '0) && (vcnt_next == '0);
        end
    end

    // Sync, blank and strobe decode of the current raster position
    always_comb begin
        h_vis        = hcnt_reg < H_ACT_C;
        v_vis        = vcnt_reg < V_ACT_C;
        active       = h_vis && v_vis;
        hs           = (hcnt_reg >= HS_START && hcnt_reg < HS_END) ? HS_POL : ~HS_POL;
        vs           = (vcnt_reg >= VS_START && vcnt_reg < VS_END) ? VS_POL : ~VS_POL;
        line_last    = v_vis && (hcnt_reg == H_LAST_ACT);
        frame_last   = (hcnt_reg == H_LAST) && (vcnt_reg == V_LAST);
        vblank_start = (hcnt_reg == H_ACT_C) && (vcnt_reg == V_LAST_ACT);
    end

    assign frame_start = frame_start_reg;

endmodule

// File: rtl/vga_scan_engine.sv
// VGA scan-out: raster timing, multiplier-free framebuffer addressing with
// pixel replication, two-page display with vblank flip, and sync/blank
// delay so they leave aligned with the palette colour.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   SCALE_LOG2 = 0,
    parameter int   ADDR_W     = 19,
    parameter int   IDX_W      = 8,
    parameter int   FB_LAT     = 1,
    parameter int   PAL_LAT    = 1
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              flip_req,
    output logic              flip_ack,
    output logic              page_disp,
    output logic [ADDR_W-1:0] fb_rdaddr,
    input  logic [IDX_W-1:0]  fb_rdata,
    output logic [IDX_W-1:0]  pal_addr,
    input  logic [23:0]       pal_bgr,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic [7:0]        b_data,
    output logic [7:0]        g_data,
    output logic [7:0]        r_data,
    output logic              frame_start
);
    localparam int REP         = 1 << SCALE_LOG2;
    localparam int SW          = H_ACTIVE >> SCALE_LOG2;
    localparam int FRAME_WORDS = SW * (V_ACTIVE >> SCALE_LOG2);
    localparam int L           = 3 + FB_LAT + PAL_LAT;

    localparam logic [ADDR_W-1:0] SW_A       = ADDR_W'(SW);
    localparam logic [ADDR_W-1:0] PAGE1_BASE = ADDR_W'(FRAME_WORDS);
    localparam logic [3:0]        REP_LAST   = 4'(REP - 1);
    localparam sync_t             SYNC_IDLE  = '{hs: ~HS_POL, vs: ~VS_POL, blank_n: 1'b0};

    generate
        if (SCALE_LOG2 < 0 || SCALE_LOG2 > 3) begin : g_bad_scale_range
            $error("vga_scan_engine: SCALE_LOG2 must be 0..3");
        end
        if ((H_ACTIVE % REP) != 0 || (V_ACTIVE % REP) != 0) begin : g_bad_scale_div
            $error("vga_scan_engine: H_ACTIVE and V_ACTIVE must be multiples of 2^SCALE_LOG2");
        end
        if ((64'(2) * 64'(FRAME_WORDS)) > (64'd1 << ADDR_W)) begin : g_bad_addr_w
            $error("vga_scan_engine: two pages do not fit in ADDR_W");
        end
        if (FB_LAT < 1 || PAL_LAT < 1) begin : g_bad_lat
            $error("vga_scan_engine: FB_LAT and PAL_LAT must be at least 1");
        end
    endgenerate

    logic t_hs, t_vs, t_active, t_line_last, t_frame_last, t_vblank_start;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) u_timing (
        .iVGA_CLK     (iVGA_CLK),
        .iRST_n       (iRST_n),
        .hs           (t_hs),
        .vs           (t_vs),
        .active       (t_active),
        .line_last    (t_line_last),
        .frame_last   (t_frame_last),
        .vblank_start (t_vblank_start),
        .frame_start  (frame_start)
    );

    logic [ADDR_W-1:0] row_base_reg, row_base_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [3:0]        hrep_reg, hrep_next;
    logic [3:0]        vrep_reg, vrep_next;
    logic [ADDR_W-1:0] fb_rdaddr_reg;
    logic [ADDR_W-1:0] page_base;
    logic              page_reg, pend_reg, flip_ack_reg;
    logic [IDX_W-1:0]  pal_addr_reg;
    logic [23:0]       colour_reg;
    sync_t             sync_raw;
    sync_t             sync_pipe [L];

    assign page_base = page_reg ? PAGE1_BASE : '0;

    // Address walk: step every REP pixels, rewind at line end, advance a row every REP lines
    always_comb begin
        row_base_next = row_base_reg;
        addr_next     = addr_reg;
        hrep_next     = hrep_reg;
        vrep_next     = vrep_reg;
        if (t_frame_last) begin
            row_base_next = page_base;
            addr_next     = page_base;
            hrep_next     = '0;
            vrep_next     = '0;
        end else if (t_line_last) begin
            hrep_next = '0;
            if (vrep_reg == REP_LAST) begin
                vrep_next     = '0;
                row_base_next = row_base_reg + SW_A;
                addr_next     = row_base_reg + SW_A;
            end else begin
                vrep_next = vrep_reg + 1'b1;
                addr_next = row_base_reg;
            end
        end else if (t_active) begin
            if (hrep_reg == REP_LAST) begin
                hrep_next = '0;
                addr_next = addr_reg + 1'b1;
            end else begin
                hrep_next = hrep_reg + 1'b1;
            end
        end
    end

    // Address state and the read-address register, which holds through blanking
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            row_base_reg  <= '0;
            addr_reg      <= '0;
            hrep_reg      <= '0;
            vrep_reg      <= '0;
            fb_rdaddr_reg <= '0;
        end else begin
            row_base_reg  <= row_base_next;
            addr_reg      <= addr_next;
            hrep_reg      <= hrep_next;
            vrep_reg      <= vrep_next;
            if (t_active) begin
                fb_rdaddr_reg <= addr_reg;
            end
        end
    end

    // Page flip: requests seen during active video are remembered until vblank;
    // the level at the vblank sample point also counts, so a held request flips every frame
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            page_reg     <= 1'b0;
            pend_reg     <= 1'b0;
            flip_ack_reg <= 1'b0;
        end else if (t_vblank_start && (flip_req || pend_reg)) begin
            page_reg     <= ~page_reg;
            pend_reg     <= 1'b0;
            flip_ack_reg <= 1'b1;
        end else begin
            flip_ack_reg <= 1'b0;
            if (t_active && flip_req) begin
                pend_reg <= 1'b1;
            end
        end
    end

    assign sync_raw = '{hs: t_hs, vs: t_vs, blank_n: t_active};

    // Data pipeline plus the L-deep sync/blank delay line aligned with colour
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pal_addr_reg <= '0;
            colour_reg   <= '0;
            for (int i = 0; i < L; i++) begin
                sync_pipe[i] <= SYNC_IDLE;
            end
        end else begin
            pal_addr_reg <= fb_rdata;
            colour_reg   <= sync_pipe[L-2].blank_n ? pal_bgr : 24'd0;
            sync_pipe[0] <= sync_raw;
            for (int i = 1; i < L; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign fb_rdaddr = fb_rdaddr_reg;
    assign pal_addr  = pal_addr_reg;
    assign page_disp = page_reg;
    assign flip_ack  = flip_ack_reg;
    assign oHS       = sync_pipe[L-1].hs;
    assign oVS       = sync_pipe[L-1].vs;
    assign oBLANK_n  = sync_pipe[L-1].blank_n;
    assign b_data    = colour_reg[B_LSB +: 8];
    assign g_data    = colour_reg[G_LSB +: 8];
    assign r_data    = colour_reg[R_LSB +: 8];

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine on a tiny 14x7 raster (8x4 visible).
// dut0: SCALE_LOG2=0, dut1: SCALE_LOG2=1; both FB_LAT=PAL_LAT=1, so L=5.
// cyc counts negedges since the last reset release; at cyc the counters hold
// raster position cyc (h = cyc%14, v = (cyc/14)%7).
module tb_vga_scan_engine;

    logic clk;
    logic rst_n;

    logic       flip_req0, flip_ack0, page0, hs0, vs0, blank0, fs0;
    logic [7:0] rdaddr0, rdata0, pal_addr0, b0, g0, r0;
    logic [23:0] bgr0;

    logic       flip_req1, flip_ack1, page1, hs1, vs1, blank1, fs1;
    logic [7:0] rdaddr1, rdata1, pal_addr1, b1, g1, r1;
    logic [23:0] bgr1;

    int checks;
    int failures;
    int cyc;

    vga_scan_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_LOG2(0),
        .ADDR_W(8), .IDX_W(8), .FB_LAT(1), .PAL_LAT(1)
    ) dut0 (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .flip_req(flip_req0), .flip_ack(flip_ack0), .page_disp(page0),
        .fb_rdaddr(rdaddr0), .fb_rdata(rdata0),
        .pal_addr(pal_addr0), .pal_bgr(bgr0),
        .oHS(hs0), .oVS(vs0), .oBLANK_n(blank0),
        .b_data(b0), .g_data(g0), .r_data(r0),
        .frame_start(fs0)
    );

    vga_scan_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_LOG2(1),
        .ADDR_W(8), .IDX_W(8), .FB_LAT(1), .PAL_LAT(1)
    ) dut1 (
        .iVGA_CLK(clk), .iRST_n(rst_n),
        .flip_req(flip_req1), .flip_ack(flip_ack1), .page_disp(page1),
        .fb_rdaddr(rdaddr1), .fb_rdata(rdata1),
        .pal_addr(pal_addr1), .pal_bgr(bgr1),
        .oHS(hs1), .oVS(vs1), .oBLANK_n(blank1),
        .b_data(b1), .g_data(g1), .r_data(r1),
        .frame_start(fs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer returns its address LSBs; palette lanes b=idx, g=~idx, r=idx+1
    always @(posedge clk) begin
        rdata0 <= rdaddr0;
        bgr0   <= {pal_addr0, ~pal_addr0, pal_addr0 + 8'd1};
        rdata1 <= rdaddr1;
        bgr1   <= {pal_addr1, ~pal_addr1, pal_addr1 + 8'd1};
    end

    function automatic int hpos(int p);
        return p % 14;
    endfunction

    function automatic int vpos(int p);
        return (p / 14) % 7;
    endfunction

    function automatic logic is_act(int p);
        return (p >= 0) && (hpos(p) < 8) && (vpos(p) < 4);
    endfunction

    function automatic logic [7:0] addr0_of(int p);
        return 8'(vpos(p) * 8 + hpos(p));
    endfunction

    function automatic logic [7:0] addr1_of(int p);
        return 8'((vpos(p) / 2) * 4 + hpos(p) / 2);
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flip_req0 = 1'b0;
        flip_req1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (hs0 !== 1'b1)       begin failures++; $display("FAIL reset_hs got=%b exp=1", hs0); end
        checks++; if (vs0 !== 1'b1)       begin failures++; $display("FAIL reset_vs got=%b exp=1", vs0); end
        checks++; if (blank0 !== 1'b0)    begin failures++; $display("FAIL reset_blank got=%b exp=0", blank0); end
        checks++; if (rdaddr0 !== 8'd0)   begin failures++; $display("FAIL reset_rdaddr got=%0d exp=0", rdaddr0); end
        checks++; if ({b0, g0, r0} !== 24'd0) begin failures++; $display("FAIL reset_colour got=%h exp=0", {b0, g0, r0}); end
        checks++; if (page0 !== 1'b0)     begin failures++; $display("FAIL reset_page got=%b exp=0", page0); end
        checks++; if (flip_ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", flip_ack0); end
        checks++; if (fs0 !== 1'b0)       begin failures++; $display("FAIL reset_fs got=%b exp=0", fs0); end
        checks++; if (rdaddr1 !== 8'd0 || blank1 !== 1'b0) begin failures++; $display("FAIL reset_dut1 rdaddr=%0d blank=%b exp=0/0", rdaddr1, blank1); end
        rst_n = 1'b1;
        cyc   = 0;
        $display("test_reset: outputs checked in reset, released at cyc 0");
    endtask

    task automatic test_sync();
        int   hs_low = 0, vs_low = 0, bl_hi = 0, p;
        logic exp_hs, exp_vs, exp_bl, exp_fs;
        while (cyc < 196) begin
            p      = cyc - 5;
            exp_hs = (p >= 0 && hpos(p) >= 10 && hpos(p) < 12) ? 1'b0 : 1'b1;
            exp_vs = (p >= 0 && vpos(p) == 5) ? 1'b0 : 1'b1;
            exp_bl = is_act(p);
            exp_fs = (cyc > 0) && (cyc % 98 == 0);
            checks++; if (hs0 !== exp_hs)    begin failures++; $display("FAIL sync_hs cyc=%0d got=%b exp=%b", cyc, hs0, exp_hs); end
            checks++; if (vs0 !== exp_vs)    begin failures++; $display("FAIL sync_vs cyc=%0d got=%b exp=%b", cyc, vs0, exp_vs); end
            checks++; if (blank0 !== exp_bl) begin failures++; $display("FAIL sync_blank cyc=%0d got=%b exp=%b", cyc, blank0, exp_bl); end
            checks++; if (fs0 !== exp_fs)    begin failures++; $display("FAIL frame_start cyc=%0d got=%b exp=%b", cyc, fs0, exp_fs); end
            if (cyc >= 5 && cyc < 103) begin
                if (hs0 === 1'b0) hs_low++;
                if (vs0 === 1'b0) vs_low++;
                if (blank0 === 1'b1) bl_hi++;
            end
            step();
        end
        checks++; if (hs_low != 14) begin failures++; $display("FAIL hs_low_count got=%0d exp=14", hs_low); end
        checks++; if (vs_low != 14) begin failures++; $display("FAIL vs_low_count got=%0d exp=14", vs_low); end
        checks++; if (bl_hi != 32)  begin failures++; $display("FAIL blank_hi_count got=%0d exp=32", bl_hi); end
        $display("test_sync: hs_low=%0d vs_low=%0d blank_hi=%0d per frame", hs_low, vs_low, bl_hi);
    endtask

    task automatic test_colour();
        logic [7:0] exp_rd = 8'd31;
        logic [7:0] idx;
        int         n_vis = 0, p;
        while (cyc < 294) begin
            p = cyc - 5;
            if (is_act(cyc - 1)) exp_rd = addr0_of(cyc - 1);
            checks++; if (rdaddr0 !== exp_rd) begin failures++; $display("FAIL colour_rdaddr cyc=%0d got=%0d exp=%0d", cyc, rdaddr0, exp_rd); end
            if (is_act(cyc - 3)) begin
                checks++; if (pal_addr0 !== addr0_of(cyc - 3)) begin failures++; $display("FAIL pal_addr cyc=%0d got=%0d exp=%0d", cyc, pal_addr0, addr0_of(cyc - 3)); end
            end
            if (is_act(p)) begin
                idx = addr0_of(p);
                checks++; if ({b0, g0, r0} !== {idx, ~idx, idx + 8'd1}) begin failures++; $display("FAIL colour cyc=%0d got=%h exp=%h", cyc, {b0, g0, r0}, {idx, ~idx, idx + 8'd1}); end
            end else begin
                checks++; if ({b0, g0, r0} !== 24'd0) begin failures++; $display("FAIL colour_blank cyc=%0d got=%h exp=0", cyc, {b0, g0, r0}); end
            end
            if (blank0 === 1'b1) n_vis++;
            step();
        end
        checks++; if (n_vis != 32) begin failures++; $display("FAIL colour_count got=%0d exp=32", n_vis); end
        $display("test_colour: %0d visible pixels, indices 0..31", n_vis);
    endtask

    task automatic test_scale();
        logic [7:0] exp_rd = 8'd7;
        logic [7:0] max_rd = 8'd0;
        while (cyc < 392) begin
            if (is_act(cyc - 1)) exp_rd = addr1_of(cyc - 1);
            checks++; if (rdaddr1 !== exp_rd) begin failures++; $display("FAIL scale_rdaddr cyc=%0d got=%0d exp=%0d", cyc, rdaddr1, exp_rd); end
            if (rdaddr1 > max_rd) max_rd = rdaddr1;
            step();
        end
        checks++; if (max_rd !== 8'd7) begin failures++; $display("FAIL scale_words got=%0d exp=7", max_rd); end
        $display("test_scale: max address %0d", max_rd);
    endtask

    task automatic test_flip_single();
        while (cyc < 409) begin
            checks++; if (flip_ack0 !== 1'b0 || page0 !== 1'b0) begin failures++; $display("FAIL flip_pre cyc=%0d ack=%b page=%b exp=0/0", cyc, flip_ack0, page0); end
            step();
        end
        flip_req0 = 1'b1;
        step();
        flip_req0 = 1'b0;
        while (cyc <= 442) begin
            checks++; if (flip_ack0 !== 1'b0 || page0 !== 1'b0) begin failures++; $display("FAIL flip_deferred cyc=%0d ack=%b page=%b exp=0/0", cyc, flip_ack0, page0); end
            step();
        end
        checks++; if (flip_ack0 !== 1'b1 || page0 !== 1'b1) begin failures++; $display("FAIL flip_take cyc=%0d ack=%b page=%b exp=1/1", cyc, flip_ack0, page0); end
        step();
        while (cyc < 560) begin
            checks++; if (flip_ack0 !== 1'b0 || page0 !== 1'b1) begin failures++; $display("FAIL flip_post cyc=%0d ack=%b page=%b exp=0/1", cyc, flip_ack0, page0); end
            if (cyc == 490) begin
                checks++; if (rdaddr0 !== 8'd31) begin failures++; $display("FAIL flip_hold got=%0d exp=31", rdaddr0); end
            end
            if (cyc == 491) begin
                checks++; if (rdaddr0 !== 8'd32) begin failures++; $display("FAIL flip_first_addr got=%0d exp=32", rdaddr0); end
            end
            if (cyc == 492) begin
                checks++; if (rdaddr0 !== 8'd33) begin failures++; $display("FAIL flip_second_addr got=%0d exp=33", rdaddr0); end
            end
            if (cyc == 495) begin
                checks++; if (b0 !== 8'd32) begin failures++; $display("FAIL flip_colour got=%0d exp=32", b0); end
            end
            step();
        end
        $display("test_flip_single: ack at cyc 443, page 1, next frame base 32");
    endtask

    task automatic test_reset_midframe();
        logic exp_fs;
        while (cyc < 621) step();
        checks++; if (rdaddr0 !== 8'd52 || blank0 !== 1'b1) begin failures++; $display("FAIL pre_reset rdaddr=%0d blank=%b exp=52/1", rdaddr0, blank0); end
        rst_n = 1'b0;
        #1;
        checks++; if (rdaddr0 !== 8'd0)   begin failures++; $display("FAIL async_rdaddr got=%0d exp=0", rdaddr0); end
        checks++; if (page0 !== 1'b0)     begin failures++; $display("FAIL async_page got=%b exp=0", page0); end
        checks++; if (blank0 !== 1'b0 || hs0 !== 1'b1 || vs0 !== 1'b1) begin failures++; $display("FAIL async_sync blank=%b hs=%b vs=%b exp=0/1/1", blank0, hs0, vs0); end
        checks++; if ({b0, g0, r0} !== 24'd0 || pal_addr0 !== 8'd0) begin failures++; $display("FAIL async_data colour=%h pal=%0d exp=0/0", {b0, g0, r0}, pal_addr0); end
        checks++; if (flip_ack0 !== 1'b0 || fs0 !== 1'b0) begin failures++; $display("FAIL async_pulses ack=%b fs=%b exp=0/0", flip_ack0, fs0); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        while (cyc <= 98) begin
            exp_fs = (cyc == 98);
            checks++; if (fs0 !== exp_fs) begin failures++; $display("FAIL restart_fs cyc=%0d got=%b exp=%b", cyc, fs0, exp_fs); end
            checks++; if (blank0 !== is_act(cyc - 5)) begin failures++; $display("FAIL restart_blank cyc=%0d got=%b exp=%b", cyc, blank0, is_act(cyc - 5)); end
            if (cyc >= 1 && cyc <= 3) begin
                checks++; if (rdaddr0 !== 8'(cyc - 1)) begin failures++; $display("FAIL restart_rdaddr cyc=%0d got=%0d exp=%0d", cyc, rdaddr0, cyc - 1); end
            end
            if (cyc == 98) break;
            step();
        end
        $display("test_reset_midframe: async clear, restart from (0,0), first frame_start at cyc 98");
    endtask

    task automatic test_flip_held();
        int   acks = 0;
        logic exp_page;
        flip_req0 = 1'b1;
        while (cyc < 392) begin
            if (flip_ack0 === 1'b1) begin
                acks++;
                exp_page = acks[0];
                checks++; if (page0 !== exp_page) begin failures++; $display("FAIL held_page ack=%0d got=%b exp=%b", acks, page0, exp_page); end
                checks++; if (cyc % 98 != 51) begin failures++; $display("FAIL held_ack_pos cyc=%0d got=%0d exp=51", cyc, cyc % 98); end
            end
            step();
        end
        flip_req0 = 1'b0;
        checks++; if (acks != 3) begin failures++; $display("FAIL held_ack_count got=%0d exp=3", acks); end
        while (cyc < 490) begin
            checks++; if (flip_ack0 !== 1'b0 || page0 !== 1'b1) begin failures++; $display("FAIL held_release cyc=%0d ack=%b page=%b exp=0/1", cyc, flip_ack0, page0); end
            step();
        end
        $display("test_flip_held: %0d acks over 3 frames, page sequence 1,0,1", acks);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        flip_req0 = 1'b0;
        flip_req1 = 1'b0;
        test_reset();
        test_sync();
        test_colour();
        test_scale();
        test_flip_single();
        test_reset_midframe();
        test_flip_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
